// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the registered immediate generator.
// Imported by the interface, the extractor and the pipeline top.
package imm_gen_pkg;

   typedef enum logic [2:0] {
      FMT_NONE  = 3'd0,
      FMT_I     = 3'd1,
      FMT_S     = 3'd2,
      FMT_B     = 3'd3,
      FMT_U     = 3'd4,
      FMT_J     = 3'd5,
      FMT_SHAMT = 3'd6,
      FMT_CSRZ  = 3'd7
   } imm_fmt_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out handshake bundle of the decode-stage immediate generator.
// master = producer/consumer side, slave = the pipeline block.
interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
);
   import imm_gen_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_inst;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_inst;
   logic [TAG_W-1:0] out_tag;
   logic [XLEN-1:0]  out_imm;
   imm_fmt_e         out_fmt;
   logic             out_unknown;

   modport master (
      output in_valid, in_inst, in_tag, out_ready,
      input  in_ready, out_valid, out_inst, out_tag, out_imm, out_fmt, out_unknown
   );

   modport slave (
      input  in_valid, in_inst, in_tag, out_ready,
      output in_ready, out_valid, out_inst, out_tag, out_imm, out_fmt, out_unknown
   );

endinterface

// File: rtl/imm_gen_pipe_imm_extract.sv
// Combinational RV immediate extraction: instruction word -> extended immediate, format, unknown flag.
// Every path assigns all outputs through the defaults at the top of the block.
module imm_extract
   import imm_gen_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter bit SLTIU_ZEXT = 1'b0
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm,
   output imm_fmt_e        fmt,
   output logic            unknown
);

   localparam int SH_W = (XLEN == 64) ? 6 : 5;

   logic [6:0] opc;
   logic [2:0] f3;

   assign opc = inst[6:0];
   assign f3  = inst[14:12];

   always_comb begin
      imm     = '0;
      fmt     = FMT_NONE;
      unknown = 1'b0;
      case (opc)
         OPC_OPIMM: begin
            if (f3 == 3'b001 || f3 == 3'b101) begin
               // shift amount only; funct7 bits above it are opcode, not immediate
               fmt            = FMT_SHAMT;
               imm[SH_W-1:0]  = inst[20 +: SH_W];
            end else if (f3 == 3'b011 && SLTIU_ZEXT) begin
               fmt       = FMT_I;
               imm[11:0] = inst[31:20];
            end else begin
               fmt = FMT_I;
               imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
            end
         end
         OPC_LOAD, OPC_JALR: begin
            fmt = FMT_I;
            imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
         end
         OPC_STORE: begin
            fmt = FMT_S;
            imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
         end
         OPC_BRANCH: begin
            fmt = FMT_B;
            imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            fmt = FMT_U;
            imm = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
         end
         OPC_JAL: begin
            fmt = FMT_J;
            imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         end
         OPC_SYSTEM: begin
            if (f3[2]) begin
               fmt      = FMT_CSRZ;
               imm[4:0] = inst[19:15];
            end
         end
         OPC_OP, OPC_FENCE: begin
            fmt = FMT_NONE;
         end
         default: begin
            unknown = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer (output register + skid register).
// state | meaning:  EMPTY = nothing held | ONE = output reg full | TWO = output + skid full
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int TAG_W      = 8,
   parameter bit SLTIU_ZEXT = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   imm_gen_pipe_if.slave bus
);

   skid_state_e state_q, state_d;

   logic [31:0]      out_inst_q, out_inst_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic [XLEN-1:0]  out_imm_q, out_imm_d;
   imm_fmt_e         out_fmt_q, out_fmt_d;
   logic             out_unk_q, out_unk_d;

   logic [31:0]      skid_inst_q, skid_inst_d;
   logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
   logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
   imm_fmt_e         skid_fmt_q, skid_fmt_d;
   logic             skid_unk_q, skid_unk_d;

   logic [XLEN-1:0] ext_imm;
   imm_fmt_e        ext_fmt;
   logic            ext_unk;

   logic in_ready, out_valid, in_xfer, out_xfer;
   logic load_out_in, load_out_skid, load_skid_in;

   imm_extract #(
      .XLEN       (XLEN),
      .SLTIU_ZEXT (SLTIU_ZEXT)
   ) u_extract (
      .inst    (bus.in_inst),
      .imm     (ext_imm),
      .fmt     (ext_fmt),
      .unknown (ext_unk)
   );

   // both handshake outputs decode from the state register only
   assign in_ready  = (state_q != ST_TWO);
   assign out_valid = (state_q != ST_EMPTY);
   assign in_xfer   = bus.in_valid && in_ready;
   assign out_xfer  = out_valid && bus.out_ready;

   always_comb begin
      state_d       = state_q;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid_in  = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               load_out_in = 1'b1;
               state_d     = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_xfer && out_xfer) begin
               load_out_in = 1'b1;
            end else if (in_xfer) begin
               load_skid_in = 1'b1;
               state_d      = ST_TWO;
            end else if (out_xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (out_xfer) begin
               load_out_skid = 1'b1;
               state_d       = ST_ONE;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
      end
   end

   always_comb begin
      out_inst_d  = out_inst_q;
      out_tag_d   = out_tag_q;
      out_imm_d   = out_imm_q;
      out_fmt_d   = out_fmt_q;
      out_unk_d   = out_unk_q;
      skid_inst_d = skid_inst_q;
      skid_tag_d  = skid_tag_q;
      skid_imm_d  = skid_imm_q;
      skid_fmt_d  = skid_fmt_q;
      skid_unk_d  = skid_unk_q;
      if (load_out_in) begin
         out_inst_d = bus.in_inst;
         out_tag_d  = bus.in_tag;
         out_imm_d  = ext_imm;
         out_fmt_d  = ext_fmt;
         out_unk_d  = ext_unk;
      end else if (load_out_skid) begin
         out_inst_d = skid_inst_q;
         out_tag_d  = skid_tag_q;
         out_imm_d  = skid_imm_q;
         out_fmt_d  = skid_fmt_q;
         out_unk_d  = skid_unk_q;
      end
      if (load_skid_in) begin
         skid_inst_d = bus.in_inst;
         skid_tag_d  = bus.in_tag;
         skid_imm_d  = ext_imm;
         skid_fmt_d  = ext_fmt;
         skid_unk_d  = ext_unk;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         out_inst_q  <= '0;
         out_tag_q   <= '0;
         out_imm_q   <= '0;
         out_fmt_q   <= FMT_NONE;
         out_unk_q   <= 1'b0;
         skid_inst_q <= '0;
         skid_tag_q  <= '0;
         skid_imm_q  <= '0;
         skid_fmt_q  <= FMT_NONE;
         skid_unk_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_inst_q  <= out_inst_d;
         out_tag_q   <= out_tag_d;
         out_imm_q   <= out_imm_d;
         out_fmt_q   <= out_fmt_d;
         out_unk_q   <= out_unk_d;
         skid_inst_q <= skid_inst_d;
         skid_tag_q  <= skid_tag_d;
         skid_imm_q  <= skid_imm_d;
         skid_fmt_q  <= skid_fmt_d;
         skid_unk_q  <= skid_unk_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid;
   assign bus.out_inst    = out_inst_q;
   assign bus.out_tag     = out_tag_q;
   assign bus.out_imm     = out_imm_q;
   assign bus.out_fmt     = out_fmt_q;
   assign bus.out_unknown = out_unk_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit sign-extending instance and a 64-bit zero-extending-SLTIU
// instance run in lockstep against a queue of expected entries.
module tb_imm_gen_pipe;
   import imm_gen_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   always #5 clk = ~clk;

   imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) b32 ();
   imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) b64 ();

   assign b64.in_valid  = b32.in_valid;
   assign b64.in_inst   = b32.in_inst;
   assign b64.in_tag    = b32.in_tag;
   assign b64.out_ready = b32.out_ready;

   imm_gen_pipe #(.XLEN(32), .TAG_W(8), .SLTIU_ZEXT(1'b0)) dut32 (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (b32.slave)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(8), .SLTIU_ZEXT(1'b1)) dut64 (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (b64.slave)
   );

   typedef struct {
      logic [7:0]  tag;
      logic [31:0] inst;
      logic [63:0] e32;
      logic [63:0] e64;
      logic [2:0]  fmt;
      logic        unk;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   bit   rnd_done;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   // reference decode: place the immediate field at the top of a 64-bit word, then shift arithmetically
   function automatic void ref_dec(input logic [31:0] i, input bit x64, input bit zext,
                                   output logic [63:0] imm, output logic [2:0] fmt, output logic unk);
      logic signed [63:0] t;
      logic [2:0] f3;
      f3  = i[14:12];
      t   = '0;
      fmt = 3'd0;
      unk = 1'b0;
      case (i[6:0])
         7'b0010011: begin
            if (f3 == 3'b001 || f3 == 3'b101) begin
               fmt = 3'd6;
               t   = x64 ? {58'b0, i[25:20]} : {59'b0, i[24:20]};
            end else if (f3 == 3'b011 && zext) begin
               fmt = 3'd1;
               t   = {52'b0, i[31:20]};
            end else begin
               fmt = 3'd1;
               t   = $signed({i[31:20], 52'b0}) >>> 52;
            end
         end
         7'b0000011, 7'b1100111: begin fmt = 3'd1; t = $signed({i[31:20], 52'b0}) >>> 52; end
         7'b0100011: begin fmt = 3'd2; t = $signed({i[31:25], i[11:7], 52'b0}) >>> 52; end
         7'b1100011: begin fmt = 3'd3; t = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0, 51'b0}) >>> 51; end
         7'b0110111, 7'b0010111: begin fmt = 3'd4; t = $signed({i[31:12], 44'b0}) >>> 32; end
         7'b1101111: begin fmt = 3'd5; t = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0, 43'b0}) >>> 43; end
         7'b1110011: begin
            if (f3[2]) begin fmt = 3'd7; t = {59'b0, i[19:15]}; end
         end
         7'b0110011, 7'b0001111: ;
         default: unk = 1'b1;
      endcase
      imm = x64 ? t : {32'b0, t[31:0]};
   endfunction

   // scoreboard: push on accepted input, pop on delivered output
   always @(negedge clk) begin
      if (!rst) begin
         if (b32.out_valid && b32.out_ready && !flush) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("tag32", 64'(b32.out_tag), 64'(e.tag));
               chk("inst32", 64'(b32.out_inst), 64'(e.inst));
               chk("imm32", 64'(b32.out_imm), e.e32);
               chk("fmt32", 64'(b32.out_fmt), 64'(e.fmt));
               chk("unk32", 64'(b32.out_unknown), 64'(e.unk));
               chk("valid64", 64'(b64.out_valid), 64'd1);
               chk("tag64", 64'(b64.out_tag), 64'(e.tag));
               chk("imm64", b64.out_imm, e.e64);
               chk("fmt64", 64'(b64.out_fmt), 64'(e.fmt));
            end
         end
         if (flush) begin
            sb.delete();
         end else if (b32.in_valid && b32.in_ready) begin
            exp_t n;
            logic [2:0] f2;
            logic u2;
            n.tag  = b32.in_tag;
            n.inst = b32.in_inst;
            ref_dec(b32.in_inst, 1'b0, 1'b0, n.e32, n.fmt, n.unk);
            ref_dec(b32.in_inst, 1'b1, 1'b1, n.e64, f2, u2);
            sb.push_back(n);
         end
      end
   end

   // called at posedge+1; returns at posedge+1 just after the accepting edge
   task automatic send(input logic [31:0] inst, input logic [7:0] tag);
      int  n;
      bit  acc;
      n   = 0;
      acc = 1'b0;
      b32.in_valid = 1'b1;
      b32.in_inst  = inst;
      b32.in_tag   = tag;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = b32.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      chk("send_accept", 64'(acc), 64'd1);
      b32.in_valid = 1'b0;
   endtask

   task automatic send_chk(input string nm, input logic [31:0] inst, input logic [7:0] tag,
                           input logic [63:0] e32, input logic [63:0] e64,
                           input imm_fmt_e fmt, input logic unk);
      send(inst, tag);
      @(negedge clk);
      chk({nm, "_v"}, 64'(b32.out_valid), 64'd1);
      chk({nm, "_i32"}, 64'(b32.out_imm), e32);
      chk({nm, "_i64"}, b64.out_imm, e64);
      chk({nm, "_f"}, 64'(b32.out_fmt), 64'(fmt));
      chk({nm, "_u"}, 64'(b32.out_unknown), 64'(unk));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      b32.out_ready = 1'b1;
      while ((sb.size() != 0 || b32.out_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_ov"}, 64'(b32.out_valid), 64'd0);
      chk({nm, "_ir"}, 64'(b32.in_ready), 64'd1);
      chk({nm, "_imm"}, 64'(b32.out_imm), 64'd0);
      chk({nm, "_inst"}, 64'(b32.out_inst), 64'd0);
      chk({nm, "_tag"}, 64'(b32.out_tag), 64'd0);
      chk({nm, "_fmt"}, 64'(b32.out_fmt), 64'(FMT_NONE));
      chk({nm, "_unk"}, 64'(b32.out_unknown), 64'd0);
      chk({nm, "_ov64"}, 64'(b64.out_valid), 64'd0);
      chk({nm, "_imm64"}, b64.out_imm, 64'd0);
   endtask

   initial begin
      logic [6:0] opcs [12];
      opcs = '{7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
               7'b1101111, 7'b1100111, 7'b1110011, 7'b0110011, 7'b0001111, 7'b0101011};
      rst           = 1'b1;
      flush         = 1'b0;
      b32.in_valid  = 1'b0;
      b32.in_inst   = '0;
      b32.in_tag    = '0;
      b32.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      send_chk("addi", 32'hFFF00093, 8'h01, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0);
      send_chk("srai", 32'h4050D093, 8'h02, 64'h5, 64'h5, FMT_SHAMT, 1'b0);
      send_chk("beq", 32'hFE000EE3, 8'h03, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_B, 1'b0);
      send_chk("sltiu", 32'hFFF0B093, 8'h04, 64'hFFFFFFFF, 64'h0000000000000FFF, FMT_I, 1'b0);
      send_chk("lui", 32'h800000B7, 8'h05, 64'h80000000, 64'hFFFFFFFF80000000, FMT_U, 1'b0);
      send_chk("unk", 32'h0000007F, 8'h06, 64'h0, 64'h0, FMT_NONE, 1'b1);
      send_chk("csrrwi", 32'h340FD073, 8'h07, 64'h1F, 64'h1F, FMT_CSRZ, 1'b0);
      drain();

      // back-pressure: tags 1..3 with the consumer stalled for three edges
      b32.out_ready = 1'b0;
      fork
         begin
            send(32'h00100093, 8'd1);
            send(32'h00200093, 8'd2);
            send(32'h00300093, 8'd3);
         end
         begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("bp_ready_low", 64'(b32.in_ready), 64'd0);
            @(posedge clk);
            #1;
            b32.out_ready = 1'b1;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("bp_no_gap", 64'(b32.out_valid), 64'd1);
               chk("bp_order", 64'(b32.out_tag), 64'(k + 1));
               @(posedge clk);
               #1;
            end
         end
      join
      drain();

      // flush while holding two entries, with a competing input
      b32.out_ready = 1'b0;
      send(32'h00A00093, 8'd10);
      send(32'h00B00093, 8'd11);
      @(negedge clk);
      chk("fl_two", 64'(b32.in_ready), 64'd0);
      @(posedge clk);
      #1;
      flush        = 1'b1;
      b32.in_valid = 1'b1;
      b32.in_inst  = 32'h00C00093;
      b32.in_tag   = 8'd12;
      @(posedge clk);
      #1;
      flush        = 1'b0;
      b32.in_valid = 1'b0;
      @(negedge clk);
      chk("fl_ov", 64'(b32.out_valid), 64'd0);
      chk("fl_ir", 64'(b32.in_ready), 64'd1);
      @(posedge clk);
      #1;
      b32.out_ready = 1'b1;
      send(32'h00400093, 8'd4);
      @(negedge clk);
      chk("fl_t4_v", 64'(b32.out_valid), 64'd1);
      chk("fl_t4_tag", 64'(b32.out_tag), 64'd4);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("fl_t4_alone", 64'(b32.out_valid), 64'd0);
      @(posedge clk);
      #1;

      // flush from empty beats a same-cycle accepted input
      flush        = 1'b1;
      b32.in_valid = 1'b1;
      b32.in_inst  = 32'h00D00093;
      b32.in_tag   = 8'd13;
      @(posedge clk);
      #1;
      flush        = 1'b0;
      b32.in_valid = 1'b0;
      @(negedge clk);
      chk("fl_drop_in", 64'(b32.out_valid), 64'd0);
      @(posedge clk);
      #1;

      // async reset while holding two entries
      b32.out_ready = 1'b0;
      send(32'hABC00093, 8'd20);
      send(32'h12300093, 8'd21);
      @(negedge clk);
      chk("rst_two", 64'(b32.in_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_reset_vals("rst_mid");
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      b32.out_ready = 1'b1;

      // random stream with random consumer stalls
      rnd_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 60; k++) begin
               logic [31:0] w;
               w      = $urandom();
               w[6:0] = opcs[$urandom_range(0, 11)];
               send(w, 8'(100 + k));
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               b32.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
